// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading types and helpers for the snake game
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int BTN_W = 4;

    function automatic dir_t dir_opposite(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/dir_scheduler_if.sv
// rtl/dir_scheduler_if.sv - button/tick inputs and heading outputs of the direction scheduler
interface dir_scheduler_if
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
);
    logic [BTN_W-1:0]         btn;
    logic                     tick;
    logic                     clear;
    dir_t                     cur_dir;
    logic                     turn;
    logic                     drop;
    logic [$clog2(DEPTH):0]   q_count;

    modport master (output btn, tick, clear, input cur_dir, turn, drop, q_count);
    modport slave  (input btn, tick, clear, output cur_dir, turn, drop, q_count);
endinterface

// File: rtl/dir_fifo.sv
// rtl/dir_fifo.sv - small turn queue exposing both head and tail entries
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  dir_t                   din,
    input  logic                   pop,
    output dir_t                   head,
    output dir_t                   tail,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    dir_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign tail    = mem[wr_ptr - PW'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/dir_scheduler.sv
// rtl/dir_scheduler.sv - turns button presses into a queue of legal headings, one per tick
module dir_scheduler
    import snake_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter dir_t INIT_DIR = DIR_RIGHT
) (
    input  logic            clk,
    input  logic            rst_n,
    dir_scheduler_if.slave  bus
);
    logic [BTN_W-1:0]       btn_q;
    logic [BTN_W-1:0]       press_q;
    dir_t                   cur_dir;
    logic                   turn_q;
    logic                   drop_q;
    dir_t                   cand;
    dir_t                   ref_dir;
    dir_t                   head;
    dir_t                   tail;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    logic                   found;
    logic                   multi;
    logic                   legal;
    logic                   pop;
    logic                   push;
    logic                   drop_next;

    // btn_q starts all-ones so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= '1;
            press_q <= '0;
        end else begin
            btn_q   <= bus.btn;
            press_q <= bus.btn & ~btn_q;
        end
    end

    always_comb begin
        cand = DIR_UP;
        for (int i = BTN_W - 1; i >= 0; i--) begin
            if (press_q[i]) cand = dir_t'(i[1:0]);
        end
    end

    assign found     = |press_q;
    assign multi     = (press_q & (press_q - BTN_W'(1))) != '0;
    // Legality is judged against the last heading the snake will have taken.
    assign ref_dir   = empty ? cur_dir : tail;
    assign legal     = (cand != ref_dir) && (cand != dir_opposite(ref_dir));
    assign pop       = !bus.clear && bus.tick && !empty;
    assign push      = !bus.clear && found && legal && (!full || pop);
    assign drop_next = !bus.clear && found && (multi || !push);

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.clear),
        .push  (push),
        .din   (cand),
        .pop   (pop),
        .head  (head),
        .tail  (tail),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_dir <= INIT_DIR;
            turn_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            if (bus.clear) cur_dir <= INIT_DIR;
            else if (pop)  cur_dir <= head;
            turn_q <= pop;
            drop_q <= drop_next;
        end
    end

    assign bus.cur_dir = cur_dir;
    assign bus.turn    = turn_q;
    assign bus.drop    = drop_q;
    assign bus.q_count = count;
endmodule

// File: tb/tb_dir_scheduler.sv
// tb/tb_dir_scheduler.sv - vector table, reset corners and randomized model check for dir_scheduler
module tb_dir_scheduler;
    import snake_pkg::*;

    localparam int   DEPTH = 2;
    localparam dir_t INIT  = DIR_RIGHT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dir_scheduler_if #(.DEPTH(DEPTH)) bus ();

    dir_scheduler #(.DEPTH(DEPTH), .INIT_DIR(INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] btn;
        logic       tick;
        logic       clear;
        int         cd;
        int         qc;
        logic       turn;
        logic       drop;
    } vec_t;

    vec_t vt[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int cd, int qc, logic tr, logic dr);
        chk({tag, " cur_dir"}, 32'(bus.cur_dir), 32'(cd));
        chk({tag, " q_count"}, 32'(bus.q_count), 32'(qc));
        chk({tag, " turn"}, 32'(bus.turn), 32'(tr));
        chk({tag, " drop"}, 32'(bus.drop), 32'(dr));
    endtask

    function automatic void add(logic [3:0] b, logic t, logic c, int cd, int qc, logic tr, logic dr);
        vec_t v;
        v.btn = b; v.tick = t; v.clear = c; v.cd = cd; v.qc = qc; v.turn = tr; v.drop = dr;
        vt.push_back(v);
    endfunction

    task automatic drive(logic [3:0] b, logic t, logic c);
        bus.btn = b; bus.tick = t; bus.clear = c;
    endtask

    // Reference model: queue of headings plus the press seen one cycle earlier.
    dir_t mq[$];
    int   m_cd;
    logic [3:0] m_last;
    logic [3:0] m_pend;
    logic m_turn, m_drop;

    task automatic model_step(logic [3:0] b, logic t, logic c);
        int cand, refd, nset;
        logic popping, accept;
        m_turn = 1'b0;
        m_drop = 1'b0;
        if (c) begin
            mq.delete();
            m_cd = int'(INIT);
        end else begin
            popping = t && (mq.size() > 0);
            accept  = 1'b0;
            if (m_pend != 4'b0) begin
                nset = $countones(m_pend);
                cand = 0;
                while (!m_pend[cand]) cand++;
                refd = (mq.size() > 0) ? int'(mq[$]) : m_cd;
                if (cand != refd && cand != (refd ^ 2) && (mq.size() < DEPTH || popping))
                    accept = 1'b1;
                m_drop = !accept || (nset > 1);
            end
            if (popping) begin
                m_cd = int'(mq.pop_front());
                m_turn = 1'b1;
            end
            if (accept) mq.push_back(dir_t'(cand));
        end
        m_pend = b & ~m_last;
        m_last = b;
    endtask

    initial begin
        drive(4'b0001, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk_all("reset", 1, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        add(4'b0001,0,0, 1,0,0,0); add(4'b0001,0,0, 1,0,0,0); add(4'b0000,0,0, 1,0,0,0);
        add(4'b0001,0,0, 1,0,0,0); add(4'b0000,0,0, 1,1,0,0); add(4'b0000,0,0, 1,1,0,0);
        add(4'b0000,0,0, 1,1,0,0); add(4'b0000,0,0, 1,1,0,0); add(4'b0000,1,0, 0,0,1,0);
        add(4'b0000,0,0, 0,0,0,0); add(4'b0010,0,0, 0,0,0,0); add(4'b0000,0,0, 0,1,0,0);
        add(4'b0000,1,0, 1,0,1,0); add(4'b0000,0,0, 1,0,0,0);
        add(4'b1000,0,0, 1,0,0,0); add(4'b0000,0,0, 1,0,0,1); add(4'b0000,0,0, 1,0,0,0);
        add(4'b0010,0,0, 1,0,0,0); add(4'b0000,0,0, 1,0,0,1);
        add(4'b0100,0,0, 1,0,0,0); add(4'b0000,0,0, 1,1,0,0);
        add(4'b0001,0,0, 1,1,0,0); add(4'b0000,0,0, 1,1,0,1); add(4'b0000,1,0, 2,0,1,0);
        add(4'b0010,0,0, 2,0,0,0); add(4'b0000,0,0, 2,1,0,0); add(4'b0000,1,0, 1,0,1,0);
        add(4'b0001,0,0, 1,0,0,0); add(4'b0000,0,0, 1,1,0,0); add(4'b0000,1,0, 0,0,1,0);
        add(4'b1010,0,0, 0,0,0,0); add(4'b1010,0,0, 0,1,0,1); add(4'b0000,0,0, 0,1,0,0);
        add(4'b0000,1,0, 1,0,1,0);
        add(4'b0001,0,0, 1,0,0,0); add(4'b0010,0,0, 1,1,0,0); add(4'b0000,0,0, 1,2,0,0);
        add(4'b0100,0,0, 1,2,0,0); add(4'b0000,0,0, 1,2,0,1);
        add(4'b0100,0,0, 1,2,0,0); add(4'b0000,1,0, 0,2,1,0);
        add(4'b1000,0,0, 0,2,0,0); add(4'b0000,1,1, 1,0,0,0); add(4'b0000,0,0, 1,0,0,0);

        foreach (vt[i]) begin
            drive(vt[i].btn, vt[i].tick, vt[i].clear);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vt[i].cd, vt[i].qc, vt[i].turn, vt[i].drop);
        end

        // Asynchronous reset must discard a queued turn before any clock edge.
        drive(4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("areset pre q_count", 32'(bus.q_count), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset q_count", 32'(bus.q_count), 32'd0);
        chk("areset cur_dir", 32'(bus.cur_dir), 32'(INIT));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post areset", 1, 0, 1'b0, 1'b0);

        // Randomized run against the model from a fresh reset.
        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_cd = int'(INIT);
        m_last = 4'b1111;
        m_pend = 4'b0000;
        begin
            logic [3:0] b;
            logic t, c;
            b = 4'b0000;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 2) == 0) b = 4'($urandom_range(0, 15));
                t = ($urandom_range(0, 3) == 0);
                c = ($urandom_range(0, 39) == 0);
                drive(b, t, c);
                model_step(b, t, c);
                @(negedge clk);
                chk_all($sformatf("rnd%0d", n), m_cd, mq.size(), m_turn, m_drop);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dir_scheduler.md
# dir_scheduler

Direction-command scheduler between the player buttons and the snake movement logic. Detects 0->1 transitions on four synchronized button levels, arbitrates simultaneous presses, rejects illegal turns, and buffers accepted turns in a small queue. It releases exactly one queued turn per game-step `tick`. Its `cur_dir` output is the only heading the snake core consumes.

## Interface
- `DEPTH`, 2: turn-queue depth; legal values 2 and 4.
- `INIT_DIR`, 2'd1 (RIGHT): heading loaded at reset and on `clear`.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `btn`  in  4  synchronized button levels; bit0 UP, bit1 RIGHT, bit2 DOWN, bit3 LEFT
- `tick`  in  1  one-cycle game-step strobe
- `clear`  in  1  synchronous restart: flush queue, reload `INIT_DIR`
- `cur_dir`  out  2  current heading (0 UP, 1 RIGHT, 2 DOWN, 3 LEFT)
- `turn`  out  1  one-cycle pulse: `cur_dir` changed this cycle
- `drop`  out  1  one-cycle pulse: a press was discarded
- `q_count`  out  $clog2(DEPTH)+1  queued turns

## Operation
- **Edge detect.** Per button: `press[i] = btn[i] & ~btn_q[i]`; `btn_q <= btn` every cycle.
  - `btn_q` resets to 4'b1111, so a button held through reset generates no press.
  - `clear` does not touch `btn_q`.
- **Arbitration.** When several `press` bits are set, the lowest index wins (UP > RIGHT > DOWN > LEFT). Any losing press asserts `drop`.
- **Legality.**
  - Reference heading = queue tail if the queue is non-empty, else `cur_dir`. Use pre-update state in every case.
  - The candidate is rejected (`drop`) if candidate == ref (no-op) or candidate == ref ^ 2'b10 (reversal).
- **Push.** A legal candidate is pushed if the queue is not full, or if it is full and a pop occurs in the same cycle. Otherwise it is rejected (`drop`).
- **Pop.** On `tick` with `q_count` > 0:
  - the head is popped into `cur_dir`;
  - `turn` asserts.
  - `tick` with an empty queue has no effect.
- **Same-cycle push and pop.** `q_count` is unchanged. If the queue was empty, no bypass: the new turn waits for the next `tick`.
- **Clear.**
  - Priority: `clear` > `tick` > press.
  - A `clear` cycle flushes the queue (pointers and count to 0) and sets `cur_dir` = `INIT_DIR`.
  - Any press in that cycle is ignored, and `drop` stays 0.
- **Pointers.** Wrap modulo `DEPTH`. `q_count` saturates logically at `DEPTH`: it never exceeds it and never underflows.

## Timing
- **Reset values:** `cur_dir` = `INIT_DIR`, `turn` = 0, `drop` = 0, `q_count` = 0, queue contents = 0.
- **Reset is asynchronous.** Asserting `rst_n` mid-operation discards queued turns immediately. The first press can be accepted one cycle after release, provided that button was sampled low first.
- **Push latency.** For a `btn` 0->1 sampled at edge n:
  - it is pushed at edge n+1;
  - `q_count` increments at n+1;
  - `drop`, if any, is high during the cycle after n+1 (registered).
- **Pop latency.** For `tick` sampled high at edge m:
  - `cur_dir` and `turn` update at m+1;
  - `turn` is high for exactly one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Shared package `snake_pkg`:**
  - `dir_t` (2-bit) with `DIR_UP`/`DIR_RIGHT`/`DIR_DOWN`/`DIR_LEFT` = 0..3;
  - function `dir_opposite(d)` = `d ^ 2'b10`;
  - `BTN_W` = 4.
- **Sub-module `dir_fifo`:**
  - parameterized by `DEPTH`;
  - push/pop, `head`, `tail`, `count`, `flush`;
  - same-cycle push and pop when full is legal.
- **Top level** holds the edge registers, the priority encoder, the legality check, the `cur_dir` register, and the `turn`/`drop` flops.

## Test plan
- **Reset/held button:** hold `btn`=4'b0001 through reset, release `rst_n` -> no push, `q_count`=0, `cur_dir`=1, `drop`=0.
- **Basic turn:** from RIGHT, pulse `btn[0]`, then `tick` 5 cycles later -> `q_count` 0->1->0; `cur_dir`=0 at tick+1; one `turn` pulse.
- **Reversal and duplicate:** `cur_dir`=RIGHT, press LEFT -> `drop` pulse, `q_count`=0. Then press RIGHT -> `drop`. Then queue DOWN and press UP -> `drop` (ref is tail DOWN).
- **Simultaneous presses:** `btn` 0->4'b1010 in one cycle, from UP -> RIGHT queued, LEFT dropped, one `drop` pulse.
- **Full queue** (`DEPTH`=2, from RIGHT):
  - queue UP, RIGHT, then press DOWN without `tick` -> `drop`, `q_count`=2;
  - repeat the press coincident with `tick` -> accepted, `q_count` stays 2, `cur_dir`=UP.
- **Clear vs tick:** queue 2 turns, assert `clear`+`tick`+press in one cycle -> `q_count`=0, `cur_dir`=`INIT_DIR`, `turn`=0, `drop`=0.
